// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word frames with a blocking miss FSM.
// Hits are returned combinationally in IDLE; a miss fills one word from memory.
module icache (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned TAG_W    = 26;
  localparam int unsigned N_FRAMES = 16;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                  state;
  logic [WORD_W-1:0]       miss_addr;
  logic [N_FRAMES-1:0]     valid;
  logic [TAG_W-1:0]        tags  [N_FRAMES];
  logic [WORD_W-1:0]       data  [N_FRAMES];

  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        miss_idx;
  logic                    hit_c;
  logic                    unused_bits;

  assign req_idx     = imemaddr[5:2];
  assign req_tag     = imemaddr[31:6];
  assign miss_idx    = miss_addr[5:2];
  // Byte offset never selects anything in a word-wide frame.
  assign unused_bits = ^{imemaddr[1:0]};

  assign hit_c = (state == IDLE) && imemREN && valid[req_idx] &&
                 (tags[req_idx] == req_tag);

  assign ihit     = hit_c;
  assign imemload = hit_c ? data[req_idx] : WORD_W'(0);
  assign iREN     = (state == FETCH);
  assign iaddr    = (state == FETCH) ? miss_addr : WORD_W'(0);

  // Miss FSM and frame fill; tag/data arrays are masked by valid after reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= WORD_W'(0);
      valid     <= N_FRAMES'(0);
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit_c) begin
            miss_addr <= {imemaddr[31:2], 2'b00};
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            valid[miss_idx] <= 1'b1;
            tags[miss_idx]  <= miss_addr[31:6];
            data[miss_idx]  <= iload;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle vector table routed through a
// scoreboard queue, plus an idle run and a randomised-latency fill.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst_n;
    logic        ren;
    logic [31:0] addr;
    logic        wait_in;
    logic [31:0] load_in;
    logic        chk;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  icache dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rst_n, input logic ren, input logic [31:0] addr,
                              input logic wait_in, input logic [31:0] load_in, input logic chk,
                              input logic e_hit, input logic [31:0] e_load,
                              input logic e_iren, input logic [31:0] e_iaddr, input string name);
    vec_t v;
    v.rst_n = rst_n; v.ren = ren; v.addr = addr; v.wait_in = wait_in; v.load_in = load_in;
    v.chk = chk; v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
    v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then compare the settled outputs.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge CLK);
    nRST = v.rst_n; imemREN = v.ren; imemaddr = v.addr; iwait = v.wait_in; iload = v.load_in;
    if (v.chk) sb.push_back(v);
    #2;
    if (v.chk) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        check({e.name, ".ihit"},     32'(ihit),  32'(e.e_hit));
        check({e.name, ".imemload"}, imemload,   e.e_load);
        check({e.name, ".iREN"},     32'(iREN),  32'(e.e_iren));
        check({e.name, ".iaddr"},    iaddr,      e.e_iaddr);
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    bool_done: begin end
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;

    //             rst ren addr          wt  load          chk hit load          iren iaddr
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  "reset"));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "post_reset"));
    vecs.push_back(mk(1, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "cold_miss"));
    vecs.push_back(mk(1, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        1, 32'h0,  "cold_fetch0"));
    vecs.push_back(mk(1, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        1, 32'h0,  "cold_fetch1"));
    vecs.push_back(mk(1, 1, 32'h0,        0, 32'h8C010004, 1, 0, 32'h0,        1, 32'h0,  "cold_fetch2"));
    vecs.push_back(mk(1, 1, 32'h0,        1, 32'h0,        1, 1, 32'h8C010004, 0, 32'h0,  "cold_hit"));
    vecs.push_back(mk(1, 1, 32'h3,        1, 32'h0,        1, 1, 32'h8C010004, 0, 32'h0,  "hit_offset3"));
    vecs.push_back(mk(1, 1, 32'h40,       0, 32'h3C00FFFF, 1, 0, 32'h0,        0, 32'h0,  "conflict_miss"));
    vecs.push_back(mk(1, 1, 32'h40,       0, 32'h3C00FFFF, 1, 0, 32'h0,        1, 32'h40, "conflict_fetch"));
    vecs.push_back(mk(1, 1, 32'h40,       1, 32'h0,        1, 1, 32'h3C00FFFF, 0, 32'h0,  "conflict_hit"));
    vecs.push_back(mk(1, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "evicted_miss"));
    vecs.push_back(mk(1, 1, 32'h0,        0, 32'h8C010004, 1, 0, 32'h0,        1, 32'h0,  "evicted_fetch"));
    vecs.push_back(mk(1, 1, 32'h0,        1, 32'h0,        1, 1, 32'h8C010004, 0, 32'h0,  "refill_hit"));
    vecs.push_back(mk(1, 1, 32'h4,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "mid_miss4"));
    vecs.push_back(mk(1, 1, 32'h8,        1, 32'h0,        1, 0, 32'h0,        1, 32'h4,  "mid_hold0"));
    vecs.push_back(mk(1, 0, 32'h8,        1, 32'h0,        1, 0, 32'h0,        1, 32'h4,  "mid_hold1"));
    vecs.push_back(mk(1, 1, 32'h8,        0, 32'h11111111, 1, 0, 32'h0,        1, 32'h4,  "mid_fill4"));
    vecs.push_back(mk(1, 1, 32'h8,        0, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "mid_miss8"));
    vecs.push_back(mk(1, 1, 32'h8,        0, 32'h22222222, 1, 0, 32'h0,        1, 32'h8,  "mid_fetch8"));
    vecs.push_back(mk(1, 1, 32'h8,        1, 32'h0,        1, 1, 32'h22222222, 0, 32'h0,  "mid_hit8"));
    vecs.push_back(mk(1, 1, 32'h4,        1, 32'h0,        1, 1, 32'h11111111, 0, 32'h0,  "mid_hit4"));

    foreach (vecs[i]) apply(vecs[i]);

    // Idle: no request means no hit, no fill and no frame disturbance.
    for (int i = 0; i < 10; i++)
      apply(mk(1, 0, $urandom, 0, $urandom, 1, 0, 32'h0, 0, 32'h0, "idle"));
    apply(mk(1, 1, 32'h4, 1, 32'h0, 1, 1, 32'h11111111, 0, 32'h0, "idle_keep4"));

    // Reset during a fill: no frame written, all valid cleared.
    vecs.delete();
    vecs.push_back(mk(1, 1, 32'hC,  1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "rst_miss"));
    vecs.push_back(mk(0, 1, 32'hC,  0, 32'h33333333, 1, 0, 32'h0,        1, 32'hC,  "rst_in_fetch"));
    vecs.push_back(mk(1, 0, 32'hC,  1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "rst_after"));
    vecs.push_back(mk(1, 1, 32'h0,  1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "rst_lost0"));
    vecs.push_back(mk(0, 1, 32'h0,  1, 32'h0,        1, 0, 32'h0,        1, 32'h0,  "rst_fetch0"));
    vecs.push_back(mk(1, 1, 32'hC,  1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  "rst_nofillC"));
    vecs.push_back(mk(1, 1, 32'hC,  0, 32'h44444444, 1, 0, 32'h0,        1, 32'hC,  "rst_fetchC"));
    vecs.push_back(mk(1, 1, 32'hC,  1, 32'h0,        1, 1, 32'h44444444, 0, 32'h0,  "rst_hitC"));
    foreach (vecs[i]) apply(vecs[i]);

    // Miss penalty with a random number of busy cycles.
    n = int'($urandom_range(0, 5));
    apply(mk(1, 1, 32'h100, 1, 32'h0, 1, 0, 32'h0, 0, 32'h0, "lat_miss"));
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      iwait = (k < n);
      iload = 32'hA5A50100;
      #2;
      if (!iREN) break;
      check("lat_iaddr", iaddr, 32'h100);
      cnt++;
    end
    if (iREN) begin
      checks++; failures++;
      $display("FAIL lat_timeout: got iREN=1 after 50 cycles expected fill done");
    end else begin
      check("lat_cycles", 32'(cnt), 32'(n + 1));
      check("lat_ihit", 32'(ihit), 32'h1);
      check("lat_load", imemload, 32'hA5A50100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL use one clock, CLK, and a synchronous, active-low reset, nRST; all state SHALL change only on the rising edge of CLK.
REQ-002 CLK  input  1  system clock.
REQ-003 nRST  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath instruction byte address.
REQ-006 ihit  output  1  the requested word is valid on imemload this cycle.
REQ-007 imemload  output  32  instruction word returned to the datapath.
REQ-008 iREN  output  1  memory-side read request.
REQ-009 iaddr  output  32  memory-side word address.
REQ-010 iwait  input  1  memory busy; the fill word is valid on the cycle iwait is low while iREN is high.
REQ-011 iload  input  32  memory-side read data.

Function
REQ-012 Organisation SHALL be direct-mapped: 16 frames, one 32-bit word each, with a valid bit and a 26-bit tag per frame.
REQ-013 Address split SHALL be tag = imemaddr[31:6], index = imemaddr[5:2]; imemaddr[1:0] SHALL be ignored.
REQ-014 The FSM SHALL have two states: IDLE and FETCH.
REQ-015 In IDLE with imemREN=1, a hit (valid[index]=1 and tag match) SHALL assert ihit in the same cycle, combinationally, with imemload = frame data.
REQ-016 In IDLE with imemREN=1 and a miss, the block SHALL capture imemaddr with bits [1:0] forced to 0 into a miss-address register and move to FETCH on the next edge.
REQ-017 In FETCH, iREN SHALL be 1, iaddr SHALL equal the miss-address register, and ihit SHALL be 0.
REQ-018 In FETCH, on an edge where iwait=0, the block SHALL write iload, the miss tag and valid=1 into the miss frame, and return to IDLE.
REQ-019 In FETCH with iwait=1, the block SHALL remain in FETCH with iaddr held.
REQ-020 Miss penalty SHALL be (number of iwait-high cycles + 1) FETCH cycles, then ihit on the following IDLE cycle.
REQ-021 Changes to imemaddr or imemREN during FETCH SHALL NOT alter iaddr or abort the fill. On return to IDLE, the current imemaddr SHALL be re-evaluated, and can hit or start a new miss.
REQ-022 With imemREN=0, ihit SHALL be 0, no miss SHALL start, and the frames SHALL be unchanged.
REQ-023 When ihit=0, imemload SHALL be 0x00000000.
REQ-024 When iREN=0, iaddr SHALL be 0x00000000.
REQ-025 A fill into an occupied frame SHALL overwrite it; there SHALL be no other replacement policy.
REQ-026 Frames SHALL be written only by a completing fill.

Reset
REQ-027 While nRST=0 at an edge, the block SHALL clear all valid bits, enter IDLE and clear the miss-address register. After that edge, iREN=0, iaddr=0, ihit=0 and imemload=0.
REQ-028 A reset asserted during FETCH SHALL abort the fill with no frame written; iREN SHALL be 0 after that edge.
REQ-029 Tag and data arrays need not be reset; valid=0 SHALL mask their contents.

Verification
REQ-030 Cold miss: after reset, imemREN=1, imemaddr=0x00000000, iwait high 2 cycles then low with iload=0x8C010004 -> iREN=1 for 3 cycles with iaddr=0x0 and ihit=0; next cycle ihit=1 and imemload=0x8C010004.
REQ-031 Hit: re-request 0x00000003 -> ihit=1 in the same cycle, imemload=0x8C010004, iREN=0.
REQ-032 Conflict: request 0x00000040 (index 0, new tag), fill 0x3C00FFFF -> the frame is replaced; a following request to 0x00000000 misses and iREN=1 with iaddr=0x0.
REQ-033 Address change mid-fill: miss on 0x00000004, switch imemaddr to 0x00000008 while iwait=1 -> iaddr stays 0x4 until the fill completes; then 0x8 misses with iaddr=0x8; a later request to 0x4 hits.
REQ-034 Reset mid-fill: assert nRST=0 during FETCH -> iREN=0 after that edge; a subsequent request to the previously filled 0x00000000 misses.
REQ-035 Idle: imemREN=0 with any imemaddr for 10 cycles -> ihit=0, iREN=0, imemload=0.
